// File: rtl/banked_data_memory.sv
// banked_data_memory
//   Data memory for the CPU datapath. Byte addresses 0..IMG_BYTES-1 hold an image split
//   into banks of BANK_BYTES (the last bank takes the remainder). The next WORD_DEPTH
//   addresses are 32-bit words for program variables. Requests use a valid/ready
//   handshake. Reads are registered with a latency of one cycle. An address outside both
//   regions returns an error response. A clear engine zeroes the word region after reset
//   and whenever clr_start is pulsed.
//
//   Ports
//     clk, rst         clock; asynchronous reset, active high
//     req_valid/ready  request handshake (ready is low while the clear engine runs)
//     req_we           1 = write, 0 = read
//     req_addr         unsigned request address
//     req_wdata        write data (the byte region stores [7:0])
//     clr_start        one-cycle pulse that zeroes the word region (accepted only when idle)
//     rsp_valid        response for the request accepted in the previous cycle
//     rsp_rdata        read data; byte reads are zero-extended; 0 for writes and errors
//     rsp_err          the accepted request hit neither region (0 while rsp_valid is 0)
//     busy             clear engine running
//
//   Build option DMEM_STATS_EN: adds the outputs rd_cnt, wr_cnt and err_cnt. These are
//   saturating counts of accepted reads, accepted writes and error responses.
module banked_data_memory #(
  parameter int unsigned IMG_BYTES  = 152100,
  parameter int unsigned BANK_BYTES = 10000,
  parameter int unsigned WORD_DEPTH = 256,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              clr_start,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt,
  output logic [31:0]       err_cnt
`endif
);

  localparam int unsigned NB     = (IMG_BYTES + BANK_BYTES - 1) / BANK_BYTES;
  localparam int unsigned BSEL_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned WIDX_W = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] WORD_BASE = ADDR_W'(IMG_BYTES);

  typedef enum logic { S_CLEAR, S_IDLE } state_t;
  typedef enum logic [1:0] { K_ZERO, K_BYTE, K_WORD } kind_t;

  state_t            r_state;
  logic [WIDX_W-1:0] r_clr_ptr;
  kind_t             r_kind;
  logic [BSEL_W-1:0] r_bsel;
  logic [31:0]       r_word_q;
  logic [31:0]       r_word [WORD_DEPTH];

  logic              w_accept;
  logic              w_in_img;
  logic              w_in_word;
  logic              w_err;
  logic [ADDR_W-1:0] w_word_rel;
  logic [WIDX_W-1:0] w_word_idx;
  logic              w_clr_we;
  logic [NB-1:0]     w_bank_hit;
  logic [BSEL_W-1:0] w_bank_sel;
  logic [7:0]        w_bank_q [NB];

  assign w_accept   = req_valid && req_ready;
  assign w_in_img   = req_addr < WORD_BASE;
  assign w_word_rel = req_addr - WORD_BASE;
  assign w_in_word  = !w_in_img && (w_word_rel < ADDR_W'(WORD_DEPTH));
  assign w_err      = !w_in_img && !w_in_word;
  assign w_word_idx = w_word_rel[WIDX_W-1:0];
  assign w_clr_we   = (r_state == S_CLEAR);

  // Each bank tests (addr - base) < size. An address below the base wraps to a large
  // value, so one unsigned compare per bank gives the range check and no divider is needed.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    localparam int unsigned BASE  = b * BANK_BYTES;
    localparam int unsigned SIZE  = (b == NB - 1) ? (IMG_BYTES - BASE) : BANK_BYTES;
    localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [ADDR_W-1:0] w_rel;
    logic [IDX_W-1:0]  w_idx;
    logic [7:0]        r_q;
    logic [7:0]        r_mem [SIZE];

    assign w_rel         = req_addr - ADDR_W'(BASE);
    assign w_idx         = w_rel[IDX_W-1:0];
    assign w_bank_hit[b] = w_rel < ADDR_W'(SIZE);
    assign w_bank_q[b]   = r_q;

    always_ff @(posedge clk) begin
      if (w_accept && w_bank_hit[b]) begin
        if (req_we) r_mem[w_idx] <= req_wdata[7:0];
        else        r_q          <= r_mem[w_idx];
      end
    end
  end

  always_comb begin
    w_bank_sel = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (w_bank_hit[b]) w_bank_sel = BSEL_W'(b);
    end
  end

  // Requests are never accepted while clearing, so the clear write and a request write
  // cannot collide on the word array.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_word[r_clr_ptr] <= '0;
    end else if (w_accept && w_in_word) begin
      if (req_we) r_word[w_word_idx] <= req_wdata;
      else        r_word_q           <= r_word[w_word_idx];
    end
  end

  // Clear-engine FSM with registered ready/busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_ptr == WIDX_W'(WORD_DEPTH - 1)) begin
            r_state   <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        default: begin
          if (clr_start) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
      endcase
    end
  end

  // The response kind and bank index change only when a request is accepted. The
  // selected read register changes only on a read of that bank. Together they keep
  // rsp_rdata at its last value during idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      r_kind    <= K_ZERO;
      r_bsel    <= '0;
    end else begin
      rsp_valid <= w_accept;
      rsp_err   <= w_accept && w_err;
      if (w_accept) begin
        r_bsel <= w_bank_sel;
        if (req_we || w_err) r_kind <= K_ZERO;
        else if (w_in_word)  r_kind <= K_WORD;
        else                 r_kind <= K_BYTE;
      end
    end
  end

  always_comb begin
    rsp_rdata = '0;
    case (r_kind)
      K_BYTE:  rsp_rdata = {24'b0, w_bank_q[r_bsel]};
      K_WORD:  rsp_rdata = r_word_q;
      default: rsp_rdata = '0;
    endcase
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else if (w_accept) begin
      if (!req_we && rd_cnt  != '1) rd_cnt  <= rd_cnt + 1'b1;
      if (req_we  && wr_cnt  != '1) wr_cnt  <= wr_cnt + 1'b1;
      if (w_err   && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_banked_data_memory.sv
module tb_banked_data_memory;

  localparam int unsigned IMG = 152100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        clr_start = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt, wr_cnt, err_cnt;
`endif

  banked_data_memory #(
    .IMG_BYTES (IMG),
    .BANK_BYTES(10000),
    .WORD_DEPTH(256),
    .ADDR_W    (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .clr_start(clr_start),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
`ifdef DMEM_STATS_EN
    ,
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt),
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_rd = 0, n_wr = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the oldest expectation whenever a response appears
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_latency", cyc, e.due);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        end
      end else begin
        if (rsp_err !== 1'b0) chk("err_without_valid", {31'b0, rsp_err}, 32'd0);
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          void'(sb.pop_front());
          chk("missing_rsp", 32'd0, 32'd1);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_e, input logic clr);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    clr_start = clr;
    for (int k = 0; k < 2000 && !req_ready; k++) @(negedge clk);
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{due: cyc + 1, rdata: exp_d, err: exp_e});
    if (we) n_wr++; else n_rd++;
    if (exp_e) n_err++;
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    clr_start = 1'b0;
  endtask

  // Counts negedges until busy drops; an optional clr_start pulse is injected mid-clear
  task automatic wait_clear(output int n, input int pulse_at);
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
      clr_start = (n == pulse_at);
    end
    clr_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    rst = 1'b0;
    wait_clear(n, 0);
    chk("init_clear_cycles", n, 256);
    chk("ready_after_clear", {31'b0, req_ready}, 32'd1);

    // Test 1: first word after clear
    issue(0, IMG, 0, 32'h0, 0, 0);
    // Test 2: bank boundary and last image byte
    issue(1, 9999,  32'hABCD_12EF, 32'h0, 0, 0);
    issue(1, 10000, 32'hABCD_12EF, 32'h0, 0, 0);
    issue(0, 9999,  0, 32'h0000_00EF, 0, 0);
    issue(0, 10000, 0, 32'h0000_00EF, 0, 0);
    issue(1, 10000, 32'h0000_0055, 32'h0, 0, 0);
    issue(0, 9999,  0, 32'h0000_00EF, 0, 0);
    issue(0, 10000, 0, 32'h0000_0055, 0, 0);
    issue(1, 150000, 32'h1234_565A, 32'h0, 0, 0);
    issue(0, 150000, 0, 32'h0000_005A, 0, 0);
    issue(1, IMG - 1, 32'hABCD_12EF, 32'h0, 0, 0);
    issue(0, IMG - 1, 0, 32'h0000_00EF, 0, 0);
    // Test 3: top word, read immediately after write
    issue(1, 152355, 32'hDEAD_BEEF, 32'h0, 0, 0);
    issue(0, 152355, 0, 32'hDEAD_BEEF, 0, 0);
    // Test 4: out-of-range accesses
    issue(1, 152356, 32'hFFFF_FFFF, 32'h0, 1, 0);
    issue(0, 152356, 0, 32'h0, 1, 0);
    issue(0, 32'hFFFF_FFFF, 0, 32'h0, 1, 0);
    issue(0, 152355, 0, 32'hDEAD_BEEF, 0, 0);
    issue(1, 152300, 32'h1234_5678, 32'h0, 0, 0);
    issue(0, 152300, 0, 32'h1234_5678, 0, 0);
    idle();
    idle();

    // Test 5: clear requested together with a request, second pulse mid-clear ignored
    issue(0, 152355, 0, 32'hDEAD_BEEF, 0, 1);
    idle();
    chk("clr_busy", {31'b0, busy}, 32'd1);
    chk("clr_ready", {31'b0, req_ready}, 32'd0);
    chk("hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
    wait_clear(n, 10);
    chk("clr_cycles", n, 256);
    issue(0, 152355, 0, 32'h0, 0, 0);
    issue(0, 152300, 0, 32'h0, 0, 0);
    issue(1, 152200, 32'h0000_0077, 32'h0, 0, 0);
    issue(0, 152200, 0, 32'h0000_0077, 0, 0);
    idle();
    idle();
    chk("idle_hold_rdata", rsp_rdata, 32'h0000_0077);

    // Reset when clr_ptr reaches 100
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (100) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd1);
    n_rd = 0; n_wr = 0; n_err = 0;
    @(negedge clk);
    rst = 1'b0;
    wait_clear(n, 0);
    chk("restart_clear_cycles", n, 256);
    issue(0, 152200, 0, 32'h0, 0, 0);
    issue(0, 9999, 0, 32'h0000_00EF, 0, 0);
    issue(1, 152400, 32'h1, 32'h0, 1, 0);
    idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
`ifdef DMEM_STATS_EN
    chk("rd_cnt", rd_cnt, n_rd);
    chk("wr_cnt", wr_cnt, n_wr);
    chk("err_cnt", err_cnt, n_err);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
